// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller.
// Holds the ramp FSM state encoding so the controller and any
// monitoring logic agree on the 2-bit state values.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// PWM period counter.
// Counts 0..PERIOD-1 and wraps. While clear is high the counter is
// forced to 0 on the next edge.
// Ports:
//   clk, rstn    - clock, asynchronous active-low reset
//   clear        - hold/return the counter to 0
//   active       - qualifies period_done (controller not idle)
//   cnt          - current position within the period
//   period_done  - high on the last cycle of each period while active
module pwm_period_timer
#(
    parameter int PERIOD = 16,
    parameter int CNT_W  = 4
)
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             active,
    output logic [CNT_W-1:0] cnt,
    output logic             period_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign period_done = active && (cnt == LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator with a slew-limited duty ramp.
// A new target duty is accepted whenever the controller is not ramping;
// the applied duty then moves toward it by at most STEP per period, only
// at period boundaries, so the waveform never glitches mid-period.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | disabled, counter held at 0, output low
// RAMP  | stepping cur_duty toward target once per period
// HOLD  | cur_duty equals target, waveform steady, commands accepted
//
// Ports:
//   clk, rstn    - clock, asynchronous active-low reset
//   en           - run enable; low forces IDLE on the next edge
//   cmd_valid    - new target duty offered
//   cmd_duty     - requested duty in high cycles per period
//   cmd_ready    - command accepted when high together with cmd_valid
//   pwm_out      - PWM waveform
//   period_done  - pulse on the last cycle of each period
//   busy         - high while ramping
//   cur_duty     - duty currently applied
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter  int PERIOD = 16,
    parameter  int STEP   = 1,
    localparam int DUTY_W = $clog2(PERIOD + 1)
)
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              cmd_valid,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              cmd_ready,
    output logic              pwm_out,
    output logic              period_done,
    output logic              busy,
    output logic [DUTY_W-1:0] cur_duty
);

    localparam int                CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

    pwm_state_t        state;
    pwm_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] sat_duty;
    logic [DUTY_W-1:0] duty_next;
    logic              cmd_hs;
    logic              duty_upd;
    logic              tmr_clear;
    logic              tmr_active;

    // One slew step from cur toward tgt, landing exactly on tgt when
    // the remaining distance is within STEP.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W-1:0] res;
        res = tgt;
        if (tgt > cur) begin
            if (int'(tgt - cur) > STEP) begin
                res = cur + DUTY_W'(STEP);
            end
        end else if (cur > tgt) begin
            if (int'(cur - tgt) > STEP) begin
                res = cur - DUTY_W'(STEP);
            end
        end
        return res;
    endfunction

    // Clearing on !en as well makes the counter read 0 on the same edge
    // the FSM drops into IDLE.
    assign tmr_clear  = (state == ST_IDLE) || !en;
    assign tmr_active = (state != ST_IDLE);

    pwm_period_timer #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rstn        (rstn),
        .clear       (tmr_clear),
        .active      (tmr_active),
        .cnt         (cnt),
        .period_done (period_done)
    );

    assign cmd_hs    = cmd_valid && cmd_ready;
    assign sat_duty  = (cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd_duty;
    assign duty_upd  = (state == ST_RAMP) && period_done;
    assign duty_next = step_toward(cur_duty, target);

    // cur_duty only moves on period_done, so the new value first applies
    // at cnt == 0 of the following period.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            target   <= '0;
            cur_duty <= '0;
        end else begin
            if (cmd_hs) begin
                target <= sat_duty;
            end
            if (duty_upd) begin
                cur_duty <= duty_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // HOLD compares against the registered target, so a differing
    // command moves to RAMP the cycle after its handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = (target != cur_duty) ? ST_RAMP : ST_HOLD;
                end
            end
            ST_RAMP: begin
                if (duty_upd && (duty_next == target)) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (target != cur_duty) begin
                    state_nxt = ST_RAMP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!en) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        busy      = (state == ST_RAMP);
        cmd_ready = (state != ST_RAMP);
        pwm_out   = (state != ST_IDLE) && (DUTY_W'(cnt) < cur_duty);
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

    localparam int PERIOD = 16;
    localparam int STEP   = 4;
    localparam int DUTY_W = $clog2(PERIOD + 1);

    logic              clk = 1'b0;
    logic              rstn;
    logic              en;
    logic              cmd_valid;
    logic [DUTY_W-1:0] cmd_duty;
    logic              cmd_ready;
    logic              pwm_out;
    logic              period_done;
    logic              busy;
    logic [DUTY_W-1:0] cur_duty;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.PERIOD(PERIOD), .STEP(STEP)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .cmd_valid   (cmd_valid),
        .cmd_duty    (cmd_duty),
        .cmd_ready   (cmd_ready),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .busy        (busy),
        .cur_duty    (cur_duty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command for one cycle, then wait the cycle HOLD needs to
    // see the new target.
    task automatic send_cmd(input int duty);
        cmd_valid = 1'b1;
        cmd_duty  = DUTY_W'(duty);
        tick();
        cmd_valid = 1'b0;
        tick();
    endtask

    // Wait for the next period_done, cross it, then check the step.
    task automatic ramp_step(input string tag, input int exp_duty, input int exp_busy);
        int n;
        n = 0;
        while (!period_done && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_pd_seen"}, 32'(period_done), 32'd1);
        tick();
        check({tag, "_duty"}, 32'(cur_duty), 32'(exp_duty));
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    // Sample one full period starting at cnt == 0.
    task automatic count_period(input string tag, input int exp_high);
        int n_high;
        int n_pd;
        n_high = 0;
        n_pd   = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_out) n_high++;
            if (period_done) n_pd++;
            tick();
        end
        check({tag, "_high"}, 32'(n_high), 32'(exp_high));
        check({tag, "_pd_cnt"}, 32'(n_pd), 32'd1);
    endtask

    initial begin
        rstn      = 1'b0;
        en        = 1'b0;
        cmd_valid = 1'b0;
        cmd_duty  = '0;
        #3;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_pd", 32'(period_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_duty", 32'(cur_duty), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("idle_cnt", 32'(dut.cnt), 32'd0);
        check("idle_pwm", 32'(pwm_out), 32'd0);

        // Ramp 0 -> 8
        en = 1'b1;
        send_cmd(8);
        check("t1_busy_start", 32'(busy), 32'd1);
        check("t1_ready", 32'(cmd_ready), 32'd0);
        ramp_step("t1_s1", 4, 1);
        check("t1_cnt0", 32'(dut.cnt), 32'd0);
        ramp_step("t1_s2", 8, 0);
        count_period("t1_wave", 8);

        // Async reset mid-period while pwm_out is high
        tick();
        tick();
        tick();
        check("t6_pre_pwm", 32'(pwm_out), 32'd1);
        rstn = 1'b0;
        #2;
        check("t6_pwm", 32'(pwm_out), 32'd0);
        check("t6_duty", 32'(cur_duty), 32'd0);
        check("t6_ready", 32'(cmd_ready), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_pd", 32'(period_done), 32'd0);
        #1;
        rstn = 1'b1;

        // Saturating command 20 -> 16
        send_cmd(20);
        check("t2_busy_start", 32'(busy), 32'd1);
        ramp_step("t2_s1", 4, 1);
        ramp_step("t2_s2", 8, 1);
        ramp_step("t2_s3", 12, 1);
        ramp_step("t2_s4", 16, 0);
        count_period("t2_wave", 16);

        // Down-ramp with a clamped final step
        send_cmd(6);
        check("t3_busy_start", 32'(busy), 32'd1);
        ramp_step("t3_s1", 12, 1);
        ramp_step("t3_s2", 8, 1);
        ramp_step("t3_s3", 6, 0);
        count_period("t3_wave", 6);

        // Command held during RAMP is stalled, then taken in HOLD
        send_cmd(14);
        check("t4_busy_start", 32'(busy), 32'd1);
        cmd_valid = 1'b1;
        cmd_duty  = DUTY_W'(2);
        check("t4_ready_ramp", 32'(cmd_ready), 32'd0);
        ramp_step("t4_s1", 10, 1);
        check("t4_ready_ramp2", 32'(cmd_ready), 32'd0);
        ramp_step("t4_s2", 14, 0);
        check("t4_ready_hold", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("t4_hold_busy", 32'(busy), 32'd0);
        tick();
        check("t4_busy_again", 32'(busy), 32'd1);
        ramp_step("t4_s3", 10, 1);
        ramp_step("t4_s4", 6, 1);
        ramp_step("t4_s5", 2, 0);

        // Disable mid-ramp at duty 8, then resume
        send_cmd(0);
        ramp_step("t5_zero", 0, 0);
        send_cmd(16);
        ramp_step("t5_s1", 4, 1);
        ramp_step("t5_s2", 8, 1);
        tick();
        tick();
        tick();
        check("t5_pre_pwm", 32'(pwm_out), 32'd1);
        en = 1'b0;
        tick();
        check("t5_idle_pwm", 32'(pwm_out), 32'd0);
        check("t5_idle_cnt", 32'(dut.cnt), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_ready", 32'(cmd_ready), 32'd1);
        check("t5_idle_duty", 32'(cur_duty), 32'd8);
        tick();
        tick();
        check("t5_idle_cnt2", 32'(dut.cnt), 32'd0);
        check("t5_idle_pd", 32'(period_done), 32'd0);
        en = 1'b1;
        tick();
        check("t5_resume_busy", 32'(busy), 32'd1);
        check("t5_resume_duty", 32'(cur_duty), 32'd8);
        check("t5_resume_pwm", 32'(pwm_out), 32'd1);
        ramp_step("t5_s3", 12, 1);
        ramp_step("t5_s4", 16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 16, meaning PWM period in clk cycles (>=2).
REQ-002 SHALL have parameter STEP, default 1, meaning max duty change per period (>=1).
REQ-003 SHALL have derived constant DUTY_W = $clog2(PERIOD+1), meaning duty width (not overridable).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  run enable.
REQ-007 SHALL have port cmd_valid  input  1  new target duty offered.
REQ-008 SHALL have port cmd_duty  input  DUTY_W  requested duty in cycles-high per period.
REQ-009 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-010 SHALL have port pwm_out  output  1  PWM waveform.
REQ-011 SHALL have port period_done  output  1  one-cycle pulse on last cycle of each period.
REQ-012 SHALL have port busy  output  1  high while ramping.
REQ-013 SHALL have port cur_duty  output  DUTY_W  duty currently applied.

Function
REQ-014 SHALL hold period counter cnt at 0 while state is IDLE; otherwise count 0..PERIOD-1 and wrap to 0.
REQ-015 SHALL assert period_done combinationally when state != IDLE and cnt == PERIOD-1.
REQ-016 SHALL drive pwm_out = (state != IDLE) && (cnt < cur_duty), combinational; cur_duty = PERIOD gives constant high, 0 constant low.
REQ-017 SHALL implement states IDLE, RAMP, HOLD; busy = (state == RAMP); cmd_ready = (state != RAMP).
REQ-018 SHALL, on handshake (cmd_valid && cmd_ready), register target = min(cmd_duty, PERIOD) (saturate, no wrap).
REQ-019 SHALL transition IDLE->RAMP when en=1 and target != cur_duty, IDLE->HOLD when en=1 and target == cur_duty.
REQ-020 SHALL transition HOLD->RAMP the cycle after a handshake whose saturated target differs from cur_duty; equal target stays HOLD.
REQ-021 SHALL, in RAMP on each period_done, update cur_duty by +/-STEP toward target, clamped to target (no overshoot), applied at cnt=0 of next period.
REQ-022 SHALL transition RAMP->HOLD on the same edge cur_duty becomes equal to target.
REQ-023 SHALL transition any state->IDLE on the edge after en=0 observed; cnt clears to 0; cur_duty and target retained.
REQ-024 SHALL give en=0 priority over handshake state changes; a handshake in the same cycle still updates target.
REQ-025 SHALL never change cur_duty mid-period (glitch-free waveform).

Reset
REQ-026 SHALL, while rstn=0, immediately force cnt=0, cur_duty=0, target=0, state=IDLE.
REQ-027 SHALL yield reset output values pwm_out=0, period_done=0, busy=0, cmd_ready=1, cur_duty=0.
REQ-028 SHALL treat reset mid-period or mid-ramp identically; no partial state survives.

Structure
REQ-029 SHALL place state encoding (IDLE=0, RAMP=1, HOLD=2, 2 bits) in shared package/header pwm_pkg.
REQ-030 SHALL instantiate one sub-module, pwm_period_timer (cnt, clear input, period_done output); ramp FSM and duty logic stay in pwm_ramp_ctrl.

Verification (PERIOD=16, STEP=4 unless stated)
REQ-031 SHALL verify reset, en=1, cmd_duty=8 -> busy=1; cur_duty 4 after 1st period_done, 8 after 2nd; busy=0; pwm_out high 8 of 16 cycles thereafter.
REQ-032 SHALL verify cmd_duty=20 -> target saturates to 16; cur_duty ramps 4,8,12,16; pwm_out constant high in HOLD.
REQ-033 SHALL verify from HOLD at 16, cmd_duty=6 -> cur_duty 12,8,6 (clamped last step); RAMP->HOLD on reaching 6.
REQ-034 SHALL verify cmd_valid held during RAMP -> cmd_ready=0, no target change; accepted first HOLD cycle.
REQ-035 SHALL verify en=0 mid-ramp at cur_duty=8 -> next cycle IDLE, pwm_out=0, cnt=0; en=1 resumes RAMP from cur_duty 8.
REQ-036 SHALL verify rstn pulsed low mid-period with pwm_out=1 -> pwm_out=0, cur_duty=0, cmd_ready=1 immediately, before next clk edge.
